// File: rtl/solver_job_scheduler_if.sv
// Job, result and Solver-side signals of the scheduler.
// slave = scheduler side, master = environment side.
interface solver_job_scheduler_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          job_valid;
  logic          job_ready;
  logic [1:0]    job_mode;
  logic [77:0]   job_data;
  logic [1:0]    sol_work;
  logic [59:0]   sol_data_raw;
  logic [77:0]   sol_data_enc;
  logic [77:0]   sol_out_enc;
  logic [59:0]   sol_out_raw;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_mode;
  logic [77:0]   res_data;
  logic          err_illegal;
  logic [CW-1:0] job_count;

  modport slave (
    input  job_valid, job_mode, job_data,
    input  sol_out_enc, sol_out_raw, res_ready,
    output job_ready, sol_work, sol_data_raw,
    output sol_data_enc, res_valid, res_mode,
    output res_data, err_illegal, job_count
  );

  modport master (
    output job_valid, job_mode, job_data,
    output sol_out_enc, sol_out_raw, res_ready,
    input  job_ready, sol_work, sol_data_raw,
    input  sol_data_enc, res_valid, res_mode,
    input  res_data, err_illegal, job_count
  );
endinterface

// File: rtl/solver_job_scheduler.sv
// Job FIFO feeding the Solver core one job at a time,
// waiting out its latency and presenting each result.
module solver_job_scheduler #(
  parameter int DEPTH      = 4,
  parameter int SOLVER_LAT = 2
) (
  input logic                   Clk,
  input logic                   Rst,
  solver_job_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(SOLVER_LAT + 1);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [LW-1:0] LAT_M1 = LW'(SOLVER_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  logic [1:0]    mode_q [DEPTH];
  logic [77:0]   data_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  state_t        state_q;
  logic [LW-1:0] lat_q;
  logic [1:0]    work_q;
  logic [59:0]   raw_q;
  logic [77:0]   enc_q;
  logic          rv_q;
  logic [1:0]    rmode_q;
  logic [77:0]   rdata_q;

  logic          hs, push, pop;
  logic [1:0]    hd_mode;
  logic [77:0]   hd_data;

  assign bus.job_ready = cnt_q != FULL;
  assign hs      = bus.job_valid && bus.job_ready;
  assign push    = hs && (bus.job_mode != 2'd3);
  assign pop     = (state_q == IDLE) && (cnt_q != '0);
  assign hd_mode = mode_q[rd_q];
  assign hd_data = data_q[rd_q];

  assign bus.job_count    = cnt_q;
  assign bus.err_illegal  = err_q;
  assign bus.sol_work     = work_q;
  assign bus.sol_data_raw = raw_q;
  assign bus.sol_data_enc = enc_q;
  assign bus.res_valid    = rv_q;
  assign bus.res_mode     = rmode_q;
  assign bus.res_data     = rdata_q;

  // Occupancy next state from push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Job storage; contents need no reset.
  always_ff @(posedge Clk) begin
    if (push) begin
      mode_q[wr_q] <= bus.job_mode;
      data_q[wr_q] <= bus.job_data;
    end
  end

  // Pointers, occupancy and illegal-mode pulse.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      err_q <= hs && (bus.job_mode == 2'd3);
    end
  end

  // Issue, latency wait and result hold.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      work_q  <= '0;
      raw_q   <= '0;
      enc_q   <= '0;
      rv_q    <= 1'b0;
      rmode_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (hd_mode == 2'd0) raw_q <= hd_data[59:0];
            if (hd_mode == 2'd1) enc_q <= hd_data;
            work_q  <= hd_mode;
            lat_q   <= LAT_M1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (lat_q == '0) begin
            rv_q    <= 1'b1;
            rmode_q <= work_q;
            rdata_q <= (work_q == 2'd0) ? bus.sol_out_enc
                                        : {18'b0, bus.sol_out_raw};
            state_q <= HOLD;
          end else begin
            lat_q <= lat_q - LW'(1);
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            rv_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
